// File: rtl/router_pkg.sv
// Shared router definitions: port count, address width and soft-reset timeout.
package router_pkg;

    localparam int NUM_PORTS        = 4;
    localparam int ADDR_W           = 2;
    localparam int SOFT_RST_TIMEOUT = 30;

    typedef logic [ADDR_W-1:0] port_addr_t;

    function automatic logic [NUM_PORTS-1:0] addr_onehot(input port_addr_t addr);
        addr_onehot = 4'b0001 << addr;
    endfunction

endpackage

// File: rtl/r_sync_timeout.sv
// One output port's stall counter; emits a single-cycle soft_reset after TIMEOUT
// consecutive stalled cycles and re-arms while the stall persists.
module r_sync_timeout #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic             stall_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             soft_reset_q;
    logic             soft_reset_d;

    assign stall_s = vld & ~rd;

    // Next-state: any read or empty cycle restarts the count from zero.
    always_comb begin
        cnt_d        = {CNT_W{1'b0}};
        soft_reset_d = 1'b0;
        if (!stall_s) begin
            cnt_d        = {CNT_W{1'b0}};
            soft_reset_d = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d        = {CNT_W{1'b0}};
            soft_reset_d = 1'b1;
        end else begin
            cnt_d        = cnt_q + CNT_W'(1);
            soft_reset_d = 1'b0;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= {CNT_W{1'b0}};
            soft_reset_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset = soft_reset_q;

endmodule

// File: rtl/r_sync.sv
// Router synchronizer: latches the header address, steers FIFO writes and
// full status, and times out stalled output ports.
module r_sync
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = SOFT_RST_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic              full_0,
    input  logic              full_1,
    input  logic              full_2,
    input  logic              full_3,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              empty_3,
    input  logic              read_enb_0,
    input  logic              read_enb_1,
    input  logic              read_enb_2,
    input  logic              read_enb_3,
    output logic [3:0]        write_enb,
    output logic              fifo_full,
    output logic              vld_out_0,
    output logic              vld_out_1,
    output logic              vld_out_2,
    output logic              vld_out_3,
    output logic              soft_reset_0,
    output logic              soft_reset_1,
    output logic              soft_reset_2,
    output logic              soft_reset_3
);

    port_addr_t                addr_q;
    port_addr_t                addr_d;
    logic [NUM_PORTS-1:0]      vld_s;
    logic [NUM_PORTS-1:0]      rd_s;
    logic [NUM_PORTS-1:0]      soft_reset_s;
    logic [DATA_W-1:ADDR_W]    data_unused_s;

    assign data_unused_s = data_in[DATA_W-1:ADDR_W];

    // Address capture on header decode.
    always_comb begin
        addr_d = addr_q;
        if (detect_add) begin
            addr_d = data_in[ADDR_W-1:0];
        end else begin
            addr_d = addr_q;
        end
    end

    // Latched destination address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= 2'b00;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Write steering always uses the registered address, even on the decode cycle.
    always_comb begin
        write_enb = 4'b0000;
        if (write_enb_reg) begin
            write_enb = addr_onehot(addr_q);
        end else begin
            write_enb = 4'b0000;
        end
    end

    // Full flag of the addressed FIFO back to the FSM.
    always_comb begin
        fifo_full = 1'b0;
        case (addr_q)
            2'd0:    fifo_full = full_0;
            2'd1:    fifo_full = full_1;
            2'd2:    fifo_full = full_2;
            2'd3:    fifo_full = full_3;
            default: fifo_full = 1'b0;
        endcase
    end

    assign vld_s = {~empty_3, ~empty_2, ~empty_1, ~empty_0};
    assign rd_s  = {read_enb_3, read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld_s[0];
    assign vld_out_1 = vld_s[1];
    assign vld_out_2 = vld_s[2];
    assign vld_out_3 = vld_s[3];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timeout
        r_sync_timeout #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timeout (
            .clk        (clk),
            .resetn     (resetn),
            .vld        (vld_s[p]),
            .rd         (rd_s[p]),
            .soft_reset (soft_reset_s[p])
        );
    end

    assign soft_reset_0 = soft_reset_s[0];
    assign soft_reset_1 = soft_reset_s[1];
    assign soft_reset_2 = soft_reset_s[2];
    assign soft_reset_3 = soft_reset_s[3];

endmodule

// File: tb/tb_r_sync.sv
// Directed bench for r_sync: address steering, full mux, valid, and timeouts.
module tb_r_sync;

    logic       clk;
    logic       resetn;
    logic       detect_add;
    logic [7:0] data_in;
    logic       write_enb_reg;
    logic [3:0] full_v;
    logic [3:0] empty_v;
    logic [3:0] rd_v;
    logic [3:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2, vld_out_3;
    logic       soft_reset_0, soft_reset_1, soft_reset_2, soft_reset_3;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    r_sync dut (
        .clk           (clk),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .full_0        (full_v[0]),
        .full_1        (full_v[1]),
        .full_2        (full_v[2]),
        .full_3        (full_v[3]),
        .empty_0       (empty_v[0]),
        .empty_1       (empty_v[1]),
        .empty_2       (empty_v[2]),
        .empty_3       (empty_v[3]),
        .read_enb_0    (rd_v[0]),
        .read_enb_1    (rd_v[1]),
        .read_enb_2    (rd_v[2]),
        .read_enb_3    (rd_v[3]),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .vld_out_3     (vld_out_3),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .soft_reset_3  (soft_reset_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sr_vec();
        return {soft_reset_3, soft_reset_2, soft_reset_1, soft_reset_0};
    endfunction

    initial begin
        resetn        = 1'b0;
        detect_add    = 1'b0;
        data_in       = 8'h00;
        write_enb_reg = 1'b0;
        full_v        = 4'b0001;
        empty_v       = 4'b1010;
        rd_v          = 4'b0000;
        #2;
        chk("rst_soft_reset", 32'(sr_vec()), 32'h0);
        chk("rst_fifo_full_addr0", 32'(fifo_full), 32'h1);
        write_enb_reg = 1'b1;
        #1;
        chk("rst_write_enb_addr0", 32'(write_enb), 32'h1);
        chk("rst_vld_out", 32'({vld_out_3, vld_out_2, vld_out_1, vld_out_0}), 32'h5);
        write_enb_reg = 1'b0;
        empty_v       = 4'b1111;
        full_v        = 4'b0000;
        step();
        step();
        resetn = 1'b1;
        step();

        // Address steering to port 2
        detect_add = 1'b1;
        data_in    = 8'h02;
        step();
        detect_add    = 1'b0;
        data_in       = 8'hFC;
        write_enb_reg = 1'b1;
        #1;
        chk("steer_write_enb_p2", 32'(write_enb), 32'h4);
        full_v = 4'b0100;
        #1;
        chk("steer_full_p2", 32'(fifo_full), 32'h1);
        full_v = 4'b0001;
        #1;
        chk("steer_full_other", 32'(fifo_full), 32'h0);
        write_enb_reg = 1'b0;
        #1;
        chk("steer_write_idle", 32'(write_enb), 32'h0);
        full_v = 4'b0000;

        // Same-cycle decode and write uses the old address
        detect_add = 1'b1;
        data_in    = 8'h01;
        step();
        data_in       = 8'h03;
        write_enb_reg = 1'b1;
        #1;
        chk("same_cycle_old_addr", 32'(write_enb), 32'h2);
        step();
        detect_add = 1'b0;
        #1;
        chk("same_cycle_new_addr", 32'(write_enb), 32'h8);
        write_enb_reg = 1'b0;

        // Timeout on port 0 with periodic re-fire
        empty_v = 4'b1110;
        #1;
        chk("vld_out_0_set", 32'(vld_out_0), 32'h1);
        for (int i = 1; i <= 60; i++) begin
            step();
            chk($sformatf("timeout_p0_cyc%0d", i), 32'(sr_vec()),
                32'((i == 30 || i == 60) ? 4'b0001 : 4'b0000));
        end
        chk("timeout_addr_kept", 32'(fifo_full), 32'h0);
        empty_v = 4'b1111;
        step();
        step();

        // Restart on a single read cycle
        empty_v = 4'b1110;
        for (int i = 1; i <= 29; i++) step();
        chk("restart_pre_read", 32'(soft_reset_0), 32'h0);
        rd_v = 4'b0001;
        step();
        chk("restart_read_cycle", 32'(soft_reset_0), 32'h0);
        rd_v = 4'b0000;
        for (int i = 1; i <= 30; i++) begin
            step();
            chk($sformatf("restart_p0_cyc%0d", i), 32'(soft_reset_0), 32'(i == 30));
        end
        empty_v = 4'b1111;
        step();
        step();

        // Ports 1 and 3 time out together
        empty_v = 4'b0101;
        for (int i = 1; i <= 31; i++) begin
            step();
            chk($sformatf("multi_cyc%0d", i), 32'(sr_vec()),
                32'((i == 30) ? 4'b1010 : 4'b0000));
        end
        empty_v = 4'b1111;
        step();

        // Reset mid-count clears counters and address
        detect_add = 1'b1;
        data_in    = 8'h03;
        step();
        detect_add = 1'b0;
        empty_v    = 4'b1110;
        for (int i = 1; i <= 20; i++) step();
        resetn = 1'b0;
        full_v = 4'b0001;
        write_enb_reg = 1'b1;
        #1;
        chk("midrst_addr_full", 32'(fifo_full), 32'h1);
        chk("midrst_addr_wr", 32'(write_enb), 32'h1);
        chk("midrst_soft_reset", 32'(sr_vec()), 32'h0);
        write_enb_reg = 1'b0;
        full_v = 4'b0000;
        step();
        step();
        resetn = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step();
            chk($sformatf("midrst_p0_cyc%0d", i), 32'(soft_reset_0), 32'(i == 30));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
